// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - line refill / writeback sequencer between tag arbiter and BIU
//
// Moves whole cache lines word by word between the cache data memory and the
// external bus. One transaction in flight at a time: a miss (optionally
// preceded by a victim writeback) or a forced sync of all dirty lines.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   line_miss, miss_addr          refill request and faulting address
//   replace_dirty                 victim line needs writeback first
//   entry_replace_sel             victim entry index
//   victim_pa                     base PA of the entry selected by wb_sel
//   force_sync, dirty_vec         write back every dirty entry
//   refill_pa, line_refill        refill done pulse with line-aligned address
//   writeback_complete            writeback done pulse
//   wb_sel                        entry currently being written back
//   cmem_addr/we/wdata/rdata      cache data memory port ({entry, word})
//   bus_req/we/addr/wdata/rdata   BIU port, request held until bus_ack
//   bus_ack                       one-cycle bus completion
//   busy, sync_done               FSM active, end-of-sync pulse
module cache_refill_ctrl #(
  parameter int ENTRY_NUM  = 8,
  parameter int SEL_WIDTH  = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1,
  parameter int LINE_WORDS = 256,
  parameter int WORD_BITS  = $clog2(LINE_WORDS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           line_miss,
  input  logic [31:0]                    miss_addr,
  input  logic                           replace_dirty,
  input  logic [SEL_WIDTH-1:0]           entry_replace_sel,
  input  logic [31:0]                    victim_pa,
  input  logic                           force_sync,
  input  logic [ENTRY_NUM-1:0]           dirty_vec,
  output logic [31:0]                    refill_pa,
  output logic                           line_refill,
  output logic                           writeback_complete,
  output logic [SEL_WIDTH-1:0]           wb_sel,
  output logic [SEL_WIDTH+WORD_BITS-1:0] cmem_addr,
  output logic                           cmem_we,
  output logic [31:0]                    cmem_wdata,
  input  logic [31:0]                    cmem_rdata,
  output logic                           bus_req,
  output logic                           bus_we,
  output logic [31:0]                    bus_addr,
  output logic [31:0]                    bus_wdata,
  input  logic [31:0]                    bus_rdata,
  input  logic                           bus_ack,
  output logic                           busy,
  output logic                           sync_done
);

  localparam int BASE_W = 30 - WORD_BITS;
  localparam int IDX_W  = SEL_WIDTH + 1;
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0]     SCAN_END  = IDX_W'(ENTRY_NUM);

  typedef enum logic [2:0] {
    IDLE, WB_RD, WB_BUS, WB_DONE, RF_BUS, RF_WR, RF_DONE, SYNC_SCAN
  } state_t;

  state_t               state, state_n;
  logic [WORD_BITS-1:0] cnt;
  logic                 sync_pend;
  logic                 in_miss;       // current transaction is a miss (vs. sync)
  logic [BASE_W-1:0]    miss_base_q;
  logic [BASE_W-1:0]    victim_base_q;
  logic [SEL_WIDTH-1:0] victim_q;
  logic [SEL_WIDTH-1:0] wb_sel_q;
  logic [31:0]          wdata_q;
  logic                 wb_first;      // first WB_BUS cycle: cmem_rdata not yet captured
  logic [31:0]          refill_word_q;
  logic [IDX_W-1:0]     scan_idx;      // one bit wider so ENTRY_NUM marks scan end

  logic last_word, scan_end, scan_hit;
  logic unused_bits;

  assign last_word   = (cnt == LAST_WORD);
  assign scan_end    = (scan_idx == SCAN_END);
  assign scan_hit    = !scan_end && dirty_vec[scan_idx[SEL_WIDTH-1:0]];
  assign wb_sel      = wb_sel_q;
  assign busy        = (state != IDLE);
  assign unused_bits = ^{miss_addr[WORD_BITS+1:0], victim_pa[WORD_BITS+1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n            = state;
    refill_pa          = '0;
    line_refill        = 1'b0;
    writeback_complete = 1'b0;
    cmem_addr          = '0;
    cmem_we            = 1'b0;
    cmem_wdata         = '0;
    bus_req            = 1'b0;
    bus_we             = 1'b0;
    bus_addr           = '0;
    bus_wdata          = '0;
    sync_done          = 1'b0;
    case (state)
      IDLE: begin
        if (line_miss)      state_n = replace_dirty ? WB_RD : RF_BUS;
        else if (sync_pend) state_n = SYNC_SCAN;
      end
      WB_RD: begin
        cmem_addr = {wb_sel_q, cnt};
        state_n   = WB_BUS;
      end
      WB_BUS: begin
        // Address stays on the memory so its read data holds through the request.
        cmem_addr = {wb_sel_q, cnt};
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = {victim_base_q, cnt, 2'b00};
        bus_wdata = wb_first ? cmem_rdata : wdata_q;
        if (bus_ack) state_n = last_word ? WB_DONE : WB_RD;
      end
      WB_DONE: begin
        writeback_complete = 1'b1;
        state_n            = in_miss ? RF_BUS : SYNC_SCAN;
      end
      RF_BUS: begin
        bus_req  = 1'b1;
        bus_addr = {miss_base_q, cnt, 2'b00};
        if (bus_ack) state_n = RF_WR;
      end
      RF_WR: begin
        cmem_we    = 1'b1;
        cmem_addr  = {victim_q, cnt};
        cmem_wdata = refill_word_q;
        state_n    = last_word ? RF_DONE : RF_BUS;
      end
      RF_DONE: begin
        line_refill = 1'b1;
        refill_pa   = {miss_base_q, cnt, 2'b00};
        state_n     = IDLE;
      end
      SYNC_SCAN: begin
        if (scan_end) begin
          sync_done = 1'b1;
          state_n   = IDLE;
        end else if (scan_hit) begin
          state_n = WB_RD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      sync_pend     <= 1'b0;
      in_miss       <= 1'b0;
      miss_base_q   <= '0;
      victim_base_q <= '0;
      victim_q      <= '0;
      wb_sel_q      <= '0;
      wdata_q       <= '0;
      wb_first      <= 1'b0;
      refill_word_q <= '0;
      scan_idx      <= '0;
    end else begin
      // A new force_sync wins over the clear so a late request is not lost.
      sync_pend <= force_sync | (sync_pend & ~sync_done);
      case (state)
        IDLE: begin
          if (line_miss) begin
            miss_base_q <= miss_addr[31:WORD_BITS+2];
            victim_q    <= entry_replace_sel;
            in_miss     <= 1'b1;
            if (replace_dirty) wb_sel_q <= entry_replace_sel;
          end else if (sync_pend) begin
            scan_idx <= '0;
          end
        end
        WB_RD: begin
          // victim_pa follows wb_sel, which is only settled once WB_RD is reached.
          if (cnt == '0) victim_base_q <= victim_pa[31:WORD_BITS+2];
          wb_first <= 1'b1;
        end
        WB_BUS: begin
          wb_first <= 1'b0;
          if (wb_first) wdata_q <= cmem_rdata;
          if (bus_ack)  cnt <= last_word ? '0 : cnt + WORD_BITS'(1);
        end
        WB_DONE: begin
          if (!in_miss) scan_idx <= scan_idx + IDX_W'(1);
        end
        RF_BUS: begin
          if (bus_ack) refill_word_q <= bus_rdata;
        end
        RF_WR: begin
          cnt <= last_word ? '0 : cnt + WORD_BITS'(1);
        end
        RF_DONE: begin
          in_miss <= 1'b0;
        end
        SYNC_SCAN: begin
          if (scan_hit)       wb_sel_q <= scan_idx[SEL_WIDTH-1:0];
          else if (!scan_end) scan_idx <= scan_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Line refill / writeback sequencer sitting between the cache tag arbiter and the BIU bus port. It accepts a miss (with optional dirty victim) or a forced-sync request, moves whole lines word by word between the cache data memory and the external bus, and closes each transaction with a one-cycle `line_refill` or `writeback_complete` pulse back to the tag arbiter. One transaction is in flight at a time.

## Interface
- `ENTRY_NUM`, 8, number of cache lines/entries.
- `SEL_WIDTH`, `$clog2(ENTRY_NUM)` (1 if `ENTRY_NUM`=1), entry index width.
- `LINE_WORDS`, 256, 32-bit words per line; power of two, ≥2.
- `WORD_BITS`, `$clog2(LINE_WORDS)`, word-offset width.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `line_miss`  in  1  refill request from tag arbiter.
- `miss_addr`  in  32  faulting address.
- `replace_dirty`  in  1  victim line is dirty.
- `entry_replace_sel`  in  SEL_WIDTH  victim entry.
- `victim_pa`  in  32  base PA of entry selected by `wb_sel` (combinational lookup).
- `force_sync`  in  1  pulse: write back all dirty lines.
- `dirty_vec`  in  ENTRY_NUM  per-entry dirty bits.
- `refill_pa`  out  32  line-aligned refill address.
- `line_refill`  out  1  one-cycle refill-done pulse.
- `writeback_complete`  out  1  one-cycle writeback-done pulse.
- `wb_sel`  out  SEL_WIDTH  entry being written back.
- `cmem_addr`  out  SEL_WIDTH+WORD_BITS  `{entry, word}`.
- `cmem_we`  out  1  cache data write strobe.
- `cmem_wdata`  out  32  cache write data.
- `cmem_rdata`  in  32  cache read data, valid one cycle after `cmem_addr`.
- `bus_req`  out  1  bus request, held until `bus_ack`.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  `{line_base[31:WORD_BITS+2], cnt, 2'b00}`.
- `bus_wdata`  out  32  write data.
- `bus_rdata`  in  32  read data, valid with `bus_ack`.
- `bus_ack`  in  1  one-cycle completion.
- `busy`  out  1  FSM not IDLE.
- `sync_done`  out  1  one-cycle pulse at end of forced sync.

## Operation
- States: IDLE, WB_RD, WB_BUS, WB_DONE, RF_BUS, RF_WR, RF_DONE, SYNC_SCAN.
- IDLE: if `line_miss`, latch `miss_addr`, `entry_replace_sel`, `replace_dirty`; dirty → `wb_sel`=victim, go WB_RD; clean → RF_BUS. Otherwise, if sync pending → SYNC_SCAN with scan index 0.
- `force_sync` sets a sticky sync-pending flag in any state. Miss takes priority over starting a sync; a sync already running completes before a new miss is accepted.
- WB_RD: drive `cmem_addr={wb_sel,cnt}`; next cycle latch `cmem_rdata` into `bus_wdata`, go WB_BUS.
- WB_BUS: `bus_req`=1, `bus_we`=1, `bus_addr` from latched `victim_pa` (latched on WB entry). On `bus_ack`: if `cnt`==LINE_WORDS-1, `cnt`←0 and go WB_DONE; else `cnt`+1 and go WB_RD.
- WB_DONE: `writeback_complete`=1 for one cycle. Next state is RF_BUS if a miss is being serviced, else SYNC_SCAN with index+1.
- RF_BUS: `bus_req`=1, `bus_we`=0, base = `miss_addr` line-aligned (low WORD_BITS+2 bits zero). On `bus_ack` latch `bus_rdata`, go RF_WR.
- RF_WR: `cmem_we`=1, `cmem_addr={victim,cnt}`. Last word → RF_DONE, else `cnt`+1 → RF_BUS.
- RF_DONE: `line_refill`=1 and `refill_pa` valid for one cycle; then IDLE.
- SYNC_SCAN: one entry per cycle. If `dirty_vec[idx]`, set `wb_sel`=idx and go WB_RD. After the last index, pulse `sync_done`, clear pending, go IDLE. `ENTRY_NUM`=1 wraps correctly.
- `cnt` is WORD_BITS wide and wraps to 0 only via explicit clear. It is never left nonzero in IDLE.

## Timing
- Reset (async, any state): state=IDLE, `cnt`=0, sync-pending=0, all outputs 0. `bus_req` drops immediately; the bus must tolerate an aborted request.
- Miss accept to first `bus_req`: 1 cycle if clean; 2 cycles if dirty (WB_RD precedes).
- Per word: writeback = 2 cycles + ack wait; refill = 2 cycles + ack wait (RF_WR).
- Bus outputs are stable while `bus_req`=1 and not acked. `bus_ack` without `bus_req` is ignored.
- `line_refill` and `writeback_complete` are never asserted in the same cycle. `line_miss` in the cycle after RF_DONE is already deasserted by the arbiter, so IDLE needs no guard cycle.
- `line_miss` while busy is ignored, not queued; the arbiter holds it until serviced.

## Test plan
- LINE_WORDS=4, clean miss at 0x0000_1234, victim 3, ack after 1 cycle → bus reads 0x1230,0x1234,0x1238,0x123C; cmem writes at {3,0..3}; single `line_refill` with `refill_pa`=0x0000_1230.
- Dirty miss, victim 5, `victim_pa`=0x8000_0000 → 4 bus writes 0x8000_0000..0x8000_000C carrying cmem data, `writeback_complete` pulse, then refill sequence, then `line_refill`.
- `force_sync` with `dirty_vec`=8'b1000_0101 → writebacks for entries 0, 2, 7 in order, three `writeback_complete` pulses, one `sync_done`.
- `force_sync` during a refill, plus `line_miss` at sync start → refill finishes, then miss is serviced, then sync runs.
- `bus_ack` delayed 5 cycles → `bus_addr`/`bus_wdata`/`bus_we` held constant throughout.
- `rst` asserted mid-writeback at word 2 → outputs 0 asynchronously; after release, a new clean miss starts at word 0.
